// File: rtl/attention_qkv_loader_if.sv
// Stream-in / bank-out bundle for the attention QKV loader.
// master = producer/consumer side, slave = loader side.
interface attention_qkv_loader_if #(
  parameter int unsigned HEADS = 4,
  parameter int unsigned DIM   = 4
);
  localparam int unsigned W = HEADS * DIM * 32;

  logic         start;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [W-1:0] query_flat;
  logic [W-1:0] key_flat;
  logic [W-1:0] value_flat;
  logic         qkv_valid;
  logic         qkv_ack;
  logic         busy;

  modport master (
    output start, in_valid, in_data, qkv_ack,
    input  in_ready, query_flat, key_flat, value_flat, qkv_valid, busy
  );

  modport slave (
    input  start, in_valid, in_data, qkv_ack,
    output in_ready, query_flat, key_flat, value_flat, qkv_valid, busy
  );
endinterface

// File: rtl/attention_qkv_loader.sv
// Deserializes a 32-bit word stream into head-major Q, K and V banks and
// presents them with a valid/ack handshake.
module attention_qkv_loader #(
  parameter int unsigned HEADS = 4,
  parameter int unsigned DIM   = 4
) (
  input logic                   clk,
  input logic                   reset,
  attention_qkv_loader_if.slave bus
);
  localparam int unsigned N  = HEADS * DIM;
  localparam int unsigned W  = N * 32;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Q,
    S_LOAD_K,
    S_LOAD_V,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_e;
  logic [W-1:0]    r_query;
  logic [W-1:0]    r_key;
  logic [W-1:0]    r_value;
  logic            r_in_ready;
  logic            r_qkv_valid;
  logic            r_busy;
  logic            w_accept;
  logic            w_last;

  always_comb begin
    w_state_nx = r_state;
    w_accept   = bus.in_valid && r_in_ready;
    w_last     = (r_e == CW'(N - 1));
    case (r_state)
      S_IDLE:   if (bus.start)          w_state_nx = S_LOAD_Q;
      S_LOAD_Q: if (w_accept && w_last) w_state_nx = S_LOAD_K;
      S_LOAD_K: if (w_accept && w_last) w_state_nx = S_LOAD_V;
      S_LOAD_V: if (w_accept && w_last) w_state_nx = S_DONE;
      S_DONE:   if (bus.qkv_ack)        w_state_nx = S_IDLE;
      default:                          w_state_nx = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_qkv_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == S_LOAD_Q) || (w_state_nx == S_LOAD_K) ||
                     (w_state_nx == S_LOAD_V);
      r_qkv_valid <= (w_state_nx == S_DONE);
      r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_e <= '0;
    end else if (w_accept) begin
      r_e <= w_last ? '0 : r_e + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_query <= '0;
      r_key   <= '0;
      r_value <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (r_e == CW'(i)) begin
          case (r_state)
            S_LOAD_Q: r_query[i*32 +: 32] <= bus.in_data;
            S_LOAD_K: r_key[i*32 +: 32]   <= bus.in_data;
            S_LOAD_V: r_value[i*32 +: 32] <= bus.in_data;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.qkv_valid  = r_qkv_valid;
  assign bus.busy       = r_busy;
  assign bus.query_flat = r_query;
  assign bus.key_flat   = r_key;
  assign bus.value_flat = r_value;
endmodule

// File: tb/tb_attention_qkv_loader.sv
// Directed bench for attention_qkv_loader: default 4x4 geometry plus a 1x1 instance.
module tb_attention_qkv_loader;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  attention_qkv_loader_if #(.HEADS(4), .DIM(4)) bus ();
  attention_qkv_loader_if #(.HEADS(1), .DIM(1)) bus1 ();

  attention_qkv_loader #(.HEADS(4), .DIM(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  attention_qkv_loader #(.HEADS(1), .DIM(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] bank_exp(input logic [31:0] base);
    logic [511:0] r;
    r = '0;
    for (int e = 0; e < 16; e++) r[e*32 +: 32] = base + 32'(e);
    return r;
  endfunction

  // Full 48-word load starting with a start pulse; optional 1/0 valid toggling
  // and an extra start pulse at loop cycle pulse_at (negative = none).
  task automatic load_main(input logic [31:0] base, input bit gaps, input int pulse_at,
                           input int exp_cycles, input string tag);
    int  cycles;
    int  idx;
    int  c;
    logic rdy;
    logic v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cycles = 1;
    check({tag, "_rdy_after_start"}, bus.in_ready, 1);
    check({tag, "_busy_after_start"}, bus.busy, 1);
    idx = 0;
    c = 0;
    while (!bus.qkv_valid && cycles < 300) begin
      v = (gaps ? (c % 2 == 0) : 1'b1) && (idx < 48);
      bus.in_valid = v;
      bus.in_data  = base + 32'(idx);
      bus.start    = (c == pulse_at);
      rdy = bus.in_ready;
      tick();
      cycles++;
      if (v && rdy) idx++;
      c++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check({tag, "_qkv_valid"}, bus.qkv_valid, 1);
    check({tag, "_latency"}, cycles, exp_cycles);
    check({tag, "_q_lo"}, bus.query_flat[31:0], base);
    check({tag, "_q_hi"}, bus.query_flat[511:480], base + 32'd15);
    check({tag, "_k_lo"}, bus.key_flat[31:0], base + 32'd16);
    check({tag, "_v_hi"}, bus.value_flat[511:480], base + 32'd47);
    check({tag, "_query"}, bus.query_flat, bank_exp(base));
    check({tag, "_key"}, bus.key_flat, bank_exp(base + 32'd16));
    check({tag, "_value"}, bus.value_flat, bank_exp(base + 32'd32));
  endtask

  logic [511:0] old_q;
  logic [511:0] exp_k;
  int           n1;
  int           k1;
  logic [31:0]  w1 [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = '0;  bus.qkv_ack = 1'b0;
    bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.qkv_ack = 1'b0;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_qkv_valid", bus.qkv_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_query", bus.query_flat, 0);
    check("rst_key", bus.key_flat, 0);
    check("rst_value", bus.value_flat, 0);
    reset = 1'b0;
    tick();

    // Words and ack while idle must be dropped.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.qkv_ack  = 1'b1;
    repeat (3) tick();
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_query", bus.query_flat, 0);
    bus.in_valid = 1'b0;
    bus.qkv_ack  = 1'b0;
    tick();

    // Basic load, with a start pulse landing in LOAD_K.
    load_main(32'd1, 1'b0, 20, 49, "basic");

    // Start in DONE is ignored.
    old_q = bus.query_flat;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("done_start_valid", bus.qkv_valid, 1);
    check("done_start_busy", bus.busy, 1);
    check("done_start_rdy", bus.in_ready, 0);
    check("done_start_query", bus.query_flat, old_q);

    // Ack together with start: back to IDLE, start dropped.
    bus.qkv_ack = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.qkv_ack = 1'b0;
    bus.start   = 1'b0;
    check("ack_valid", bus.qkv_valid, 0);
    check("ack_busy", bus.busy, 0);
    check("ack_rdy", bus.in_ready, 0);
    check("ack_query_held", bus.query_flat, old_q);

    // Reload immediately with valid toggling.
    load_main(32'd1, 1'b1, -1, 96, "gaps");
    bus.qkv_ack = 1'b1;
    tick();
    bus.qkv_ack = 1'b0;

    // 20 words of a new load, then reset.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h200 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    exp_k = bank_exp(32'd17);
    for (int e = 0; e < 4; e++) exp_k[e*32 +: 32] = 32'h210 + 32'(e);
    check("partial_query", bus.query_flat, bank_exp(32'h200));
    check("partial_key", bus.key_flat, exp_k);
    check("partial_value", bus.value_flat, bank_exp(32'd33));
    reset = 1'b1;
    #1;
    check("midrst_query", bus.query_flat, 0);
    check("midrst_key", bus.key_flat, 0);
    check("midrst_rdy", bus.in_ready, 0);
    check("midrst_busy", bus.busy, 0);
    #2;
    reset = 1'b0;
    tick();
    load_main(32'h300, 1'b0, -1, 49, "after_rst");
    bus.qkv_ack = 1'b1;
    tick();
    bus.qkv_ack = 1'b0;

    // 1x1 geometry: one word per bank.
    w1[0] = 32'hA0A0A0A0;
    w1[1] = 32'hB1B1B1B1;
    w1[2] = 32'hC2C2C2C2;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    n1 = 1;
    k1 = 0;
    while (!bus1.qkv_valid && n1 < 50) begin
      bus1.in_valid = (k1 < 3);
      bus1.in_data  = (k1 < 3) ? w1[k1] : 32'h0;
      tick();
      n1++;
      k1++;
    end
    bus1.in_valid = 1'b0;
    check("c1_qkv_valid", bus1.qkv_valid, 1);
    check("c1_latency", n1, 4);
    check("c1_query", bus1.query_flat, w1[0]);
    check("c1_key", bus1.key_flat, w1[1]);
    check("c1_value", bus1.value_flat, w1[2]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
